// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding valid/ready command to APB master bridge with bus-hang timeout
module apb_master_bridge #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d, rdata_q, rdata_d;
  logic pwrite_q, pwrite_d, err_q, err_d, to_q, to_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic expired;
  assign expired     = (TIMEOUT_CYCLES != 0) && (cnt_q == LAST);
  assign cmd_ready   = state_q == IDLE;
  assign PSEL        = (state_q == SETUP) || (state_q == ACCESS);
  assign PENABLE     = state_q == ACCESS;
  assign rsp_valid   = state_q == RESP;
  assign PADDR       = paddr_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = to_q;
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    to_d     = to_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        state_d  = SETUP;
        paddr_d  = cmd_addr;
        pwrite_d = cmd_write;
        pwdata_d = cmd_wdata;
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: if (PREADY) begin
        state_d = RESP;
        rdata_d = pwrite_q ? '0 : PRDATA;
        err_d   = PSLVERR;
        to_d    = 1'b0;
      end else if (expired) begin
        state_d = RESP;
        rdata_d = '0;
        err_d   = 1'b1;
        to_d    = 1'b1;
      end else cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      to_q     <= to_d;
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: table, directed and randomized checks of apb_master_bridge against a transfer-level model
module tb_apb_master_bridge;
  localparam int TO = 16;
  logic PCLK = 1'b0;
  logic PRESET = 1'b1;
  logic cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0, PRDATA = '0;
  logic PREADY = 1'b0, PSLVERR = 1'b0;
  logic cmd_ready, rsp_valid, rsp_err, rsp_timeout, PSEL, PENABLE, PWRITE;
  logic [31:0] rsp_rdata, PADDR, PWDATA;
  int tests = 0, fails = 0;
  typedef struct {
    logic wr;
    logic [31:0] addr, wdata;
    int waits;
    logic se;
    logic [31:0] prdata;
    int hold;
    logic [31:0] e_rd;
    logic e_err, e_to;
    int e_lat;
  } vec_t;
  vec_t vecs[7];
  apb_master_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );
  always #5 PCLK = ~PCLK;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic step();
    @(posedge PCLK);
    #1;
  endtask
  function automatic vec_t model(input vec_t v);
    vec_t r;
    bit t;
    r = v;
    t = v.waits >= TO;
    r.e_to = t;
    r.e_err = t | v.se;
    r.e_rd = (v.wr || t) ? 32'h0 : v.prdata;
    r.e_lat = 3 + (t ? TO - 1 : v.waits);
    return r;
  endfunction
  task automatic txn(input vec_t v);
    int cyc, acc;
    logic prev;
    chk("idle_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr = v.addr;
    cmd_wdata = v.wdata;
    rsp_ready = 1'b0;
    PREADY = 1'b0;
    PSLVERR = 1'b0;
    step();
    cmd_valid = 1'b0;
    cmd_write = ~v.wr;
    cmd_addr = $urandom;
    cmd_wdata = $urandom;
    cyc = 1;
    acc = 0;
    prev = 1'b0;
    while (!rsp_valid && cyc < 40) begin
      chk("penable_needs_psel", PENABLE & ~PSEL, 0);
      if (PSEL && !prev) chk("psel_rise_penable_low", PENABLE, 0);
      if (cyc == 1) chk("setup_phase", {PSEL, PENABLE}, 2'b10);
      if (PSEL) begin
        chk("paddr_hold", PADDR, v.addr);
        chk("pwrite_hold", PWRITE, v.wr);
        chk("pwdata_hold", PWDATA, v.wdata);
      end
      prev = PSEL;
      if (PSEL && PENABLE) begin
        acc++;
        PREADY = acc > v.waits;
        PSLVERR = PREADY ? v.se : 1'($urandom);
        PRDATA = PREADY ? v.prdata : $urandom;
      end else begin
        PREADY = 1'($urandom);
        PSLVERR = 1'($urandom);
        PRDATA = $urandom;
      end
      step();
      cyc++;
    end
    chk("rsp_latency", cyc, v.e_lat);
    chk("access_cycles", acc, v.waits < TO ? v.waits + 1 : TO);
    chk("rsp_psel_low", {PSEL, PENABLE}, 0);
    chk("rsp_rdata", rsp_rdata, v.e_rd);
    chk("rsp_err", rsp_err, v.e_err);
    chk("rsp_timeout", rsp_timeout, v.e_to);
    cmd_valid = 1'b1;
    for (int i = 0; i < v.hold; i++) begin
      PRDATA = $urandom;
      PREADY = 1'($urandom);
      PSLVERR = 1'($urandom);
      step();
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, v.e_rd);
      chk("hold_err", {rsp_err, rsp_timeout}, {v.e_err, v.e_to});
      chk("hold_psel", PSEL, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    PREADY = 1'b0;
    PSLVERR = 1'b0;
    step();
    rsp_ready = 1'b0;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_cmd_ready", cmd_ready, 1);
  endtask
  initial begin
    vec_t v;
    vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, 32'h0, 0, 32'h0, 1'b0, 1'b0, 3};
    vecs[1] = '{1'b0, 32'h24, 32'h0, 3, 1'b0, 32'hA5A50001, 0, 32'hA5A50001, 1'b0, 1'b0, 6};
    vecs[2] = '{1'b0, 32'h30, 32'h0, 1, 1'b1, 32'h1234, 0, 32'h1234, 1'b1, 1'b0, 4};
    vecs[3] = '{1'b0, 32'h40, 32'h0, 20, 1'b0, 32'h77, 0, 32'h0, 1'b1, 1'b1, 18};
    vecs[4] = '{1'b0, 32'h44, 32'h0, 15, 1'b0, 32'hCAFE, 0, 32'hCAFE, 1'b0, 1'b0, 18};
    vecs[5] = '{1'b1, 32'h50, 32'h55, 16, 1'b0, 32'h0, 1, 32'h0, 1'b1, 1'b1, 18};
    vecs[6] = '{1'b1, 32'h60, 32'h66, 2, 1'b1, 32'h0, 5, 32'h0, 1'b1, 1'b0, 5};
    repeat (3) step();
    PRESET = 1'b0;
    step();
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_ctrl", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout}, 0);
    chk("reset_paddr", PADDR, 0);
    chk("reset_pwdata", PWDATA, 0);
    chk("reset_rdata", rsp_rdata, 0);
    for (int i = 0; i < 7; i++) txn(vecs[i]);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr = 32'h80;
    step();
    cmd_valid = 1'b0;
    PREADY = 1'b0;
    repeat (2) step();
    chk("mid_access", {PSEL, PENABLE}, 2'b11);
    PRESET = 1'b1;
    step();
    chk("rst_mid_psel", {PSEL, PENABLE}, 0);
    chk("rst_mid_rsp", rsp_valid, 0);
    PRESET = 1'b0;
    step();
    chk("rst_mid_cmd_ready", cmd_ready, 1);
    chk("rst_mid_rsp_after", rsp_valid, 0);
    for (int i = 0; i < 40; i++) begin
      v.wr = 1'($urandom);
      v.addr = $urandom;
      v.wdata = $urandom;
      v.waits = $urandom_range(0, 20);
      v.se = 1'($urandom);
      v.prdata = $urandom;
      v.hold = $urandom_range(0, 3);
      txn(model(v));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
